// File: rtl/im_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package im_pkg;
   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
   } im_state_e;

   localparam int IM_SIZE = 128;
   localparam int WORD_W  = 32;
   localparam int BYTE_W  = 8;
   localparam int LEN_W   = 16;
endpackage

// File: rtl/im_word_pack.sv
// Packs four bytes, MSB first, into one 32-bit word; pulses w_word_valid with the 4th byte.
module im_word_pack import im_pkg::*; (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_byte_valid,
   input  logic [BYTE_W-1:0] i_byte,
   output logic              o_word_valid,
   output logic [WORD_W-1:0] o_word
);
   logic [1:0]        r_cnt;
   logic [WORD_W-1:0] r_sr;

   // The word is presented combinationally so the owner can register it on the 4th byte.
   assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);
   assign o_word       = {r_sr[WORD_W-BYTE_W-1:0], i_byte};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (i_byte_valid) begin
         r_cnt <= r_cnt + 2'd1;
         r_sr  <= o_word;
      end
   end
endmodule

// File: rtl/im_loader.sv
// Framed byte-stream program loader: length, big-endian words, 8-bit checksum.
module im_loader import im_pkg::*; #(
   parameter int SIZE = IM_SIZE
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [BYTE_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_we,
   output logic [WORD_W-1:0] o_waddr,
   output logic [WORD_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_hold_cpu,
   output logic              o_done,
   output logic              o_err
);
   im_state_e         r_state;
   logic              r_busy, r_we, r_done, r_err;
   logic [BYTE_W-1:0] r_len_hi, r_sum;
   logic [LEN_W-1:0]  r_n, r_idx;
   logic [WORD_W-1:0] r_waddr, r_wdata;

   logic              w_fire, w_clr, w_wv;
   logic [WORD_W-1:0] w_word;
   logic [LEN_W-1:0]  w_n;

   assign w_fire = i_in_valid && r_busy;
   assign w_clr  = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
   assign w_n    = {r_len_hi, i_in_data};

   im_word_pack u_pack (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (w_clr),
      .i_byte_valid (w_fire && r_state == DATA),
      .i_byte       (i_in_data),
      .o_word_valid (w_wv),
      .o_word       (w_word)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_busy   <= 1'b0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_len_hi <= '0;
         r_sum    <= '0;
         r_n      <= '0;
         r_idx    <= '0;
         r_waddr  <= '0;
         r_wdata  <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_wv) begin
            r_we    <= 1'b1;
            r_waddr <= {{(WORD_W-LEN_W-2){1'b0}}, r_idx, 2'b00};
            r_wdata <= w_word;
            r_idx   <= r_idx + LEN_W'(1);
         end
         case (r_state)
            IDLE, DONE, ERR: if (i_start) begin
               r_state <= LEN_HI;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_sum   <= '0;
               r_idx   <= '0;
            end
            LEN_HI: if (w_fire) begin
               r_len_hi <= i_in_data;
               r_sum    <= r_sum + i_in_data;
               r_state  <= LEN_LO;
            end
            LEN_LO: if (w_fire) begin
               r_n   <= w_n;
               r_sum <= r_sum + i_in_data;
               if (w_n == '0) begin
                  r_state <= CSUM;
               end else if (w_n > LEN_W'(SIZE)) begin
                  r_state <= ERR;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_state <= DATA;
               end
            end
            DATA: if (w_fire) begin
               r_sum <= r_sum + i_in_data;
               // Last byte of word N-1 closes the data phase.
               if (w_wv && r_idx == r_n - LEN_W'(1)) r_state <= CSUM;
            end
            CSUM: if (w_fire) begin
               r_busy <= 1'b0;
               if (i_in_data == r_sum) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready = r_busy;
   assign o_busy     = r_busy;
   assign o_hold_cpu = r_busy;
   assign o_we       = r_we;
   assign o_waddr    = r_waddr;
   assign o_wdata    = r_wdata;
   assign o_done     = r_done;
   assign o_err      = r_err;
endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed frames plus randomized frames against a frame-level model.
module tb_im_loader;
   localparam int SIZE = 128;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, we, busy, hold_cpu, done, err;
   logic [31:0] waddr, wdata;

   int n_pass = 0, n_chk = 0;
   logic [63:0] wq[$];
   logic [31:0] wd[$];

   always #5 clk = ~clk;

   im_loader #(.SIZE(SIZE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
      .i_in_data(in_data), .o_in_ready(in_ready), .o_we(we), .o_waddr(waddr),
      .o_wdata(wdata), .o_busy(busy), .o_hold_cpu(hold_cpu), .o_done(done), .o_err(err)
   );

   always @(posedge clk) if (we === 1'b1) wq.push_back({waddr, wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit gaps, input bit mid_start);
      int g;
      if (gaps) begin in_valid = 1'b0; cyc($urandom_range(0, 2)); end
      in_valid = 1'b1; in_data = b; start = mid_start;
      g = 0;
      while (in_ready !== 1'b1 && g < 20) begin cyc(1); g++; end
      if (g >= 20) chk("ready_timeout", 64'd0, 64'd1);
      cyc(1);
      in_valid = 1'b0; start = 1'b0;
   endtask

   // Frame-level model: build the byte stream from wd/nfield and predict writes and result.
   task automatic run_frame(input string tag, input int nfield, input bit bad,
                            input bit gaps, input int start_at);
      logic [7:0] q[$];
      logic [7:0] s;
      logic [31:0] w;
      bit oversize;
      int nexp;
      oversize = (nfield > SIZE);
      q.push_back(8'((nfield >> 8) & 255));
      q.push_back(8'(nfield & 255));
      if (!oversize) begin
         for (int i = 0; i < nfield; i++) begin
            w = wd[i];
            for (int k = 0; k < 4; k++) q.push_back(8'((w >> (24 - 8*k)) & 255));
         end
         s = 8'h00;
         foreach (q[i]) s = s + q[i];
         q.push_back(bad ? s + 8'd1 : s);
      end
      wq.delete();
      pulse_start();
      chk({tag, "_ready_start"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_flags_clear"}, {62'd0, done, err}, 64'd0);
      foreach (q[i]) send(q[i], gaps, (i == start_at));
      chk({tag, "_done"}, {63'd0, done}, {63'd0, !oversize && !bad});
      chk({tag, "_err"},  {63'd0, err},  {63'd0, oversize || bad});
      chk({tag, "_hold"}, {62'd0, busy, hold_cpu}, 64'd0);
      in_valid = 1'b1; in_data = 8'hA5; cyc(3); in_valid = 1'b0;
      chk({tag, "_ready_after"}, {63'd0, in_ready}, 64'd0);
      nexp = oversize ? 0 : nfield;
      chk({tag, "_nwrites"}, 64'(wq.size()), 64'(nexp));
      for (int i = 0; i < nexp && i < wq.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), wq[i], {32'(i * 4), wd[i]});
   endtask

   initial begin
      int n;
      cyc(2);
      chk("rst_outputs", {in_ready, we, busy, hold_cpu, done, err}, 64'd0);
      chk("rst_addr_data", {waddr, wdata}, 64'd0);
      rst_n = 1'b1; cyc(1);

      // Bytes offered before any start must be ignored.
      in_valid = 1'b1; in_data = 8'h55; cyc(3); in_valid = 1'b0;
      chk("idle_ignore", {61'd0, busy, in_ready, we}, 64'd0);

      wd = '{32'h20100096, 32'hAC1000FF};
      run_frame("good", 2, 1'b0, 1'b0, -1);
      chk("good_lit0", wq[0], 64'h00000000_20100096);
      chk("good_lit1", wq[1], 64'h00000004_AC1000FF);
      run_frame("badsum", 2, 1'b1, 1'b0, -1);
      run_frame("oversize", 16'h0081, 1'b0, 1'b0, -1);
      run_frame("zero", 0, 1'b0, 1'b0, -1);
      run_frame("gaps_start", 2, 1'b0, 1'b1, 5);

      // Reset mid-load after 6 bytes.
      wq.delete();
      pulse_start();
      send(8'h00, 0, 0); send(8'h02, 0, 0); send(8'h20, 0, 0);
      send(8'h10, 0, 0); send(8'h00, 0, 0); send(8'h96, 0, 0);
      rst_n = 1'b0; #1;
      chk("midrst_outputs", {in_ready, we, busy, hold_cpu, done, err}, 64'd0);
      chk("midrst_addr_data", {waddr, wdata}, 64'd0);
      cyc(2); rst_n = 1'b1; cyc(1);
      chk("midrst_nowe", 64'(wq.size()), 64'd0);
      run_frame("after_rst", 2, 1'b0, 1'b0, -1);

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(0, 6);
         wd.delete();
         for (int i = 0; i < n; i++) wd.push_back($urandom);
         run_frame($sformatf("rnd%0d", t), n, 1'($urandom_range(0, 1)), 1'b1,
                   $urandom_range(2, 8));
      end
      run_frame("rnd_over", $urandom_range(SIZE + 1, 1000), 1'b0, 1'b1, -1);

      wd.delete();
      for (int i = 0; i < SIZE; i++) wd.push_back($urandom);
      run_frame("full", SIZE, 1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/im_loader.md
# im_loader

Program loader for the instruction memory. Accepts a framed byte stream from a serial receiver (UART RX or similar), assembles big-endian 32-bit instruction words, and writes them into the instruction store at word-aligned byte addresses starting at 0. It holds the CPU in reset while loading, and reports done or error.

## Interface
- `SIZE`, 128, instruction store capacity in 32-bit words.
- `clk`  in  1  single system clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  byte available from the receiver.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader can take a byte; a byte transfers on `in_valid && in_ready`.
- `we`  out  1  one-cycle write strobe to the instruction store.
- `waddr`  out  32  byte address of the write: word index × 4.
- `wdata`  out  32  assembled instruction word.
- `busy`  out  1  load in progress.
- `hold_cpu`  out  1  equals `busy`; drives the CPU reset request.
- `done`  out  1  sticky; last load completed with a good checksum.
- `err`  out  1  sticky; last load failed.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 data bytes, each word MSB first.
  - One checksum byte, which must equal the 8-bit modular sum of all preceding frame bytes (length bytes included).
- States:
  - IDLE: `start` → LEN_HI.
  - LEN_HI: byte → LEN_LO.
  - LEN_LO: byte → DATA if 0 < N ≤ SIZE; → CSUM if N = 0; → ERR if N > SIZE.
  - DATA: after 4N bytes → CSUM.
  - CSUM: byte → DONE on match, ERR on mismatch.
  - DONE, ERR: `start` → LEN_HI.
- `in_ready` = 1 only in LEN_HI, LEN_LO, DATA and CSUM.
- `busy` = 1 in the same states.
- Entering LEN_HI clears `done`, `err`, the running sum, the byte counter and the word index.
- Running sum: 8 bits, wraps modulo 256.
- Word index: counts 0..N-1.
- `waddr` = {index, 2'b00}, zero-extended to 32 bits.
- Byte lane: the k-th byte of a word (k = 0..3) lands in bits [31-8k -: 8].
- N > SIZE: no write is issued.
- Checksum mismatch: words already written stay in memory; only `err` marks the failure.
- `start` in LEN_HI..CSUM is ignored.
- `in_valid` while `in_ready` = 0 is ignored; no byte is consumed.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `we`, `busy`, `hold_cpu`, `done`, `err` = 0.
  - `waddr`, `wdata` = 0.
  - counters and sum = 0.
- `start` sampled at edge t → state LEN_HI and `in_ready` = 1 from t+1.
- Maximum throughput is one byte per cycle; no bubbles are required.
- `we`, `waddr`, `wdata` are registered:
  - they become valid in the cycle after the 4th byte of a word is accepted;
  - `we` is high for exactly one cycle;
  - `waddr` and `wdata` hold until the next write.
- The final word's `we` occurs in the same cycle that `in_ready` is first high in CSUM.
- `done` or `err` rises, and `busy` falls, in the cycle after the deciding byte is accepted (LEN_LO when N > SIZE, otherwise CSUM).
- Reset asserted mid-load:
  - all outputs go to their reset values immediately (asynchronously);
  - a partially assembled word is discarded;
  - memory already written is not touched.
- Reset deassertion must be synchronised to `clk` externally.

## Structure
- Shared package `im_pkg`:
  - loader state enum: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR;
  - default `IM_SIZE` = 128;
  - `WORD_W` = 32, `BYTE_W` = 8, `LEN_W` = 16.
- One sub-module, `im_word_pack`:
  - 2-bit byte counter plus 32-bit shift register;
  - emits a one-cycle `word_valid` with the word;
  - has a synchronous clear.
- FSM, sum, word index and write registers live in `im_loader`.

## Test plan
- Good frame: bytes 00 02 20 10 00 96 AC 10 00 FF 83, one per cycle.
  - `we` twice: (0x0, 0x20100096) and (0x4, 0xAC1000FF).
  - `done` = 1, `err` = 0, `hold_cpu` falls.
- Same frame with checksum byte 0x84 → both writes occur, `err` = 1, `done` = 0.
- Length 0x0081 with `SIZE` = 128 → `err` one cycle after LEN_LO, no `we`, `in_ready` = 0 afterwards.
- Length 0x0000 followed by checksum 00 → `done`, no `we`.
- `in_valid` toggled randomly during the good frame, plus `start` pulsed mid-load → identical writes and result; the mid-load `start` is ignored.
- `rst_n` pulsed low after 6 bytes:
  - all outputs return to 0 with no `we`;
  - a fresh `start` plus the good frame then loads correctly.
